ecc_write_encoder: RTL

Write-path SECDED encoder for the DDR3 controller, the counterpart of the read-side `ecc_checker`. It accepts 64-bit write data beats with byte masks, computes the 8 check bits, and presents a 72-bit codeword (data + ECC) to the PHY write FIFO. It is a two-stage valid/ready pipeline with full throughput, optional test-mode error injection, and a count of emitted words.

---
 rtl/ecc_write_encoder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ecc_write_encoder.sv
// ecc_write_encoder: two-stage valid/ready SECDED encoder for the DDR3 write path.
// Stage 1 captures the beat plus per-check-bit partial parities; stage 2 folds in
// the overall parity, applies optional error injection and drives the PHY FIFO.
module ecc_write_encoder #(
  parameter bit INJ_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_mask,
  input  logic [1:0]  inj_mode,
  input  logic [6:0]  inj_bit0,
  input  logic [6:0]  inj_bit1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [7:0]  out_ecc,
  output logic [7:0]  out_mask,
  output logic [31:0] word_count
);

  // Data bits occupy the non-power-of-two positions 3..71 in ascending order.
  // Returns the set of data bits whose codeword position has bit c set.
  function automatic logic [63:0] chk_mask(input int c);
    logic [63:0] m;
    int          k;
    m = '0;
    k = 0;
    for (int pos = 1; pos < 72; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (((pos >> c) & 1) == 1) m[k[5:0]] = 1'b1;
        k++;
      end
    end
    return m;
  endfunction

  logic [6:0]  part;
  logic        s2_adv;
  logic        s1_adv;

  logic        s1_valid;
  logic [63:0] s1_data;
  logic [7:0]  s1_mask;
  logic [1:0]  s1_mode;
  logic [6:0]  s1_bit0;
  logic [6:0]  s1_bit1;
  logic [6:0]  s1_part;
  logic        s1_par;

  logic [71:0] flip;
  logic [7:0]  clean_ecc;

  // Hamming check bits c[0..6] straight from the incoming beat.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_chk
      localparam logic [63:0] MASK = chk_mask(gi);
      assign part[gi] = ^(in_data & MASK);
    end
  endgenerate

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Overall parity c[7] covers the data bits and c[0..6].
  assign clean_ecc = {s1_par ^ (^s1_part), s1_part};

  // Flip vector over the 72-bit codeword; indices above 71 flip nothing and a
  // repeated index is flipped only once.
  always_comb begin
    flip = '0;
    if (INJ_EN) begin
      if ((s1_mode == 2'b01 || s1_mode == 2'b10) && s1_bit0 <= 7'd71)
        flip[s1_bit0] = 1'b1;
      if (s1_mode == 2'b10 && s1_bit1 <= 7'd71)
        flip[s1_bit1] = 1'b1;
    end
  end

  // Stage 1: capture the accepted beat, its injection controls and partial parities.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mask  <= '0;
      s1_mode  <= '0;
      s1_bit0  <= '0;
      s1_bit1  <= '0;
      s1_part  <= '0;
      s1_par   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mask <= in_mask;
        s1_mode <= inj_mode;
        s1_bit0 <= inj_bit0;
        s1_bit1 <= inj_bit1;
        s1_part <= part;
        s1_par  <= ^in_data;
      end
    end
  end

  // Stage 2: final check bits with injection applied; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ecc   <= '0;
      out_mask  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s1_data ^ flip[63:0];
        out_ecc  <= clean_ecc ^ flip[71:64];
        out_mask <= s1_mask;
      end
    end
  end

  // Count completed output handshakes, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= '0;
    end else if (out_valid && out_ready) begin
      word_count <= word_count + 32'd1;
    end
  end

endmodule
